ddr3_ca_delay_ctrl: RTL
=======================

// Module: ddr3_ca_delay_ctrl
// PURPOSE
//  Parametrised delay-line sequencer for the DDR3 PHY address/command IOD lanes (A0..A15, BA, etc.).
//  Accepts per-lane tap requests: increment, decrement, reload or status query.
//  Issues correctly timed DELAY_LINE_MOVE/DIRECTION/LOAD pulses to the selected IOD, waits for settle
//  and checks DELAY_LINE_OUT_OF_RANGE. Keeps a shadow tap count for every lane.
//  Sits between the training/calibration engine and the NUM_LANES address IODs.
// PARAMETERS
//  NUM_LANES      15  number of IOD lanes controlled (1..32)
//  TAP_W          8   tap counter width; legal tap range 0..2**TAP_W-1
//  INIT_TAP       1   tap value after reset/LOAD (matches IOD TX_DELAY_VAL)
//  SETTLE_CYCLES  4   wait cycles after each MOVE/LOAD pulse before sampling (>=1)
//  LANE_W         $clog2(NUM_LANES) (localparam, min 1)
// PORTS
//  FAB_CLK                  in   1                fabric clock, all logic rising-edge
//  ARST                     in   1                asynchronous reset, active high
//  REQ_VALID                in   1                request valid
//  REQ_READY                out  1                block idle, request accepted when VALID&READY
//  REQ_LANE                 in   LANE_W           target lane index
//  REQ_OP                   in   2                00 inc, 01 dec, 10 load INIT_TAP, 11 status query
//  REQ_STEPS                in   TAP_W            number of taps to move (inc/dec only)
//  BUSY                     out  1                request in progress (= ~REQ_READY after reset)
//  DONE                     out  1                one-cycle completion pulse
//  DONE_STATUS              out  2                00 ok, 01 out of range/limit, 10 bad lane
//  DONE_TAP                 out  TAP_W            shadow tap of lane at completion (0 if bad lane)
//  DELAY_LINE_MOVE          out  NUM_LANES        per-lane move pulse to IOD
//  DELAY_LINE_DIRECTION     out  NUM_LANES        per-lane direction, 1 = increase delay
//  DELAY_LINE_LOAD          out  NUM_LANES        per-lane load pulse to IOD
//  DELAY_LINE_OUT_OF_RANGE  in   NUM_LANES        per-lane range flag from IOD, same clock domain
//  TAP_VALUE                out  NUM_LANES*TAP_W  shadow taps, lane i at [i*TAP_W +: TAP_W]
// BEHAVIOUR
//  Reset (ARST high, async)
//  - State IDLE; REQ_READY=0; BUSY=0; DONE=0; DONE_STATUS=0; DONE_TAP=0.
//  - MOVE/DIRECTION/LOAD all 0; every TAP_VALUE lane = INIT_TAP.
//  - REQ_READY rises on the first FAB_CLK edge after ARST falls.
//  - Reset mid-operation aborts at once: pulses stop and no DONE is issued.
//    The IOD delay line itself is not reset; the caller must issue LOAD.
//  FSM: IDLE -> SETUP -> MOVE -> SETTLE -> CHECK -> (MOVE | RESP); IDLE -> LDP -> SETTLE -> RESP; IDLE -> RESP
//  IDLE
//  - REQ_READY=1. On VALID&READY, latch lane/op/steps; REQ_READY=0 and BUSY=1 next cycle.
//  - Lane >= NUM_LANES: RESP with status 10, no pulses.
//  - Op 11, or inc/dec with STEPS=0: RESP with status 00.
//  - Op 10: LDP. Op inc/dec: SETUP.
//  SETUP
//  - DIRECTION[lane] driven (inc=1, dec=0) and held through SETUP..CHECK; 0 otherwise.
//  - Other lanes' outputs stay 0.
//  MOVE
//  - If shadow tap is already at the limit (MAX for inc, 0 for dec): no pulse, RESP with status 01.
//  - Otherwise MOVE[lane]=1 for exactly one cycle.
//  LDP: LOAD[lane]=1 for one cycle; shadow tap <= INIT_TAP.
//  SETTLE: wait exactly SETTLE_CYCLES cycles.
//  CHECK
//  - Sample OUT_OF_RANGE[lane]. If 1: shadow tap unchanged, RESP with status 01.
//  - After a move: tap +/-1, remaining-1; remaining 0 -> RESP (status 00), else MOVE.
//  - After a load: RESP (status 00); the range flag is ignored.
//  RESP
//  - DONE=1 for one cycle with DONE_STATUS and DONE_TAP (post-update shadow value).
//  - Next cycle: IDLE; REQ_READY=1 and BUSY=0.
//  Latency (accept edge = cycle 0)
//  - Immediate (bad lane / query / STEPS=0): DONE at cycle 1.
//  - Move of N taps: DONE at cycle N*(SETTLE_CYCLES+2)+2.
//  - Load: DONE at cycle SETTLE_CYCLES+3.
//  Arithmetic
//  - Shadow taps are unsigned TAP_W bits and never wrap; limit checks happen before each pulse.
//  - REQ_VALID while busy is ignored (no queueing); the caller holds it until READY.
// TESTING
//  T1: reset, lane 3 inc STEPS=3, SETTLE=4 -> 3 MOVE pulses 6 cycles apart, DIR[3]=1; DONE cycle 20, status 00, tap 4.
//  T2: lane 0 dec STEPS=5 from tap 1 -> one MOVE pulse; DONE status 01, tap 0; no second pulse.
//  T3: lane 7 inc STEPS=4, force OUT_OF_RANGE[7]=1 after 2nd move -> 2 pulses; DONE status 01, tap 2.
//  T4: REQ_LANE=NUM_LANES, and op 11 on lane 2 -> DONE at cycle 1, statuses 10/00; no MOVE/LOAD activity.
//  T5: lane 5 inc to 9, then op 10 -> LOAD[5] one pulse; DONE at cycle 7, tap 1; other TAP_VALUE lanes unchanged.
//  T6: ARST asserted mid-SETTLE of lane 4 -> outputs 0 at once; all taps=INIT_TAP; no DONE; READY 1 cycle after release.

Source files
------------

// File: rtl/ddr3_ca_delay_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : ddr3_ca_delay_ctrl
// Purpose : Delay-line sequencer for the DDR3 address/command IOD lanes.
//           Turns inc/dec/load/query requests into timed MOVE/DIRECTION/LOAD
//           pulses, waits for settle, checks the range flag and keeps a
//           shadow tap count per lane.
// Rev     : 1.0  initial release
// ============================================================================
module ddr3_ca_delay_ctrl #(
  parameter int NUM_LANES     = 15,
  parameter int TAP_W         = 8,
  parameter int INIT_TAP      = 1,
  parameter int SETTLE_CYCLES = 4,
  localparam int LANE_W       = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                       FAB_CLK,
  input  logic                       ARST,
  input  logic                       REQ_VALID,
  output logic                       REQ_READY,
  input  logic [LANE_W-1:0]          REQ_LANE,
  input  logic [1:0]                 REQ_OP,
  input  logic [TAP_W-1:0]           REQ_STEPS,
  output logic                       BUSY,
  output logic                       DONE,
  output logic [1:0]                 DONE_STATUS,
  output logic [TAP_W-1:0]           DONE_TAP,
  output logic [NUM_LANES-1:0]       DELAY_LINE_MOVE,
  output logic [NUM_LANES-1:0]       DELAY_LINE_DIRECTION,
  output logic [NUM_LANES-1:0]       DELAY_LINE_LOAD,
  input  logic [NUM_LANES-1:0]       DELAY_LINE_OUT_OF_RANGE,
  output logic [NUM_LANES*TAP_W-1:0] TAP_VALUE
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [TAP_W-1:0] TAP_INIT    = TAP_W'(INIT_TAP);
  localparam logic [TAP_W-1:0] TAP_MAX     = '1;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETUP  = 3'd1;
  localparam logic [2:0] ST_MOVE   = 3'd2;
  localparam logic [2:0] ST_SETTLE = 3'd3;
  localparam logic [2:0] ST_CHECK  = 3'd4;
  localparam logic [2:0] ST_LDP    = 3'd5;
  localparam logic [2:0] ST_RESP   = 3'd6;

  localparam logic [1:0] OP_INC  = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b10;
  localparam logic [1:0] OP_QRY  = 2'b11;

  logic [2:0]        state;
  logic [LANE_W-1:0] lane_r;
  logic [1:0]        op_r;
  logic [TAP_W-1:0]  rem_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [1:0]        status_r;
  logic              ready_en;
  logic [TAP_W-1:0]  taps [NUM_LANES];

  logic                 lane_ok;
  logic                 req_lane_ok;
  logic                 is_inc;
  logic [TAP_W-1:0]     cur_tap;
  logic                 at_limit;
  logic                 oor;
  logic [NUM_LANES-1:0] lane_hot;

  // Decode of the latched request and the selected lane's shadow tap
  always_comb begin
    lane_ok     = ({1'b0, lane_r}   < (LANE_W+1)'(NUM_LANES));
    req_lane_ok = ({1'b0, REQ_LANE} < (LANE_W+1)'(NUM_LANES));
    is_inc      = (op_r == OP_INC);
    cur_tap     = lane_ok ? taps[lane_r] : '0;
    at_limit    = is_inc ? (cur_tap == TAP_MAX) : (cur_tap == '0);
    oor         = lane_ok ? DELAY_LINE_OUT_OF_RANGE[lane_r] : 1'b0;
    lane_hot    = NUM_LANES'(1) << lane_r;
  end

  // Sequencer FSM; limit check happens in MOVE before any pulse is issued
  always_ff @(posedge FAB_CLK or posedge ARST) begin
    if (ARST) begin
      state    <= ST_IDLE;
      lane_r   <= '0;
      op_r     <= '0;
      rem_r    <= '0;
      cnt_r    <= '0;
      status_r <= '0;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (REQ_VALID && REQ_READY) begin
            lane_r   <= REQ_LANE;
            op_r     <= REQ_OP;
            rem_r    <= REQ_STEPS;
            status_r <= 2'b00;
            if (!req_lane_ok) begin
              status_r <= 2'b10;
              state    <= ST_RESP;
            end else if (REQ_OP == OP_QRY || (!REQ_OP[1] && REQ_STEPS == '0)) begin
              state <= ST_RESP;
            end else if (REQ_OP == OP_LOAD) begin
              state <= ST_LDP;
            end else begin
              state <= ST_SETUP;
            end
          end
        end
        ST_SETUP: state <= ST_MOVE;
        ST_MOVE: begin
          if (at_limit) begin
            status_r <= 2'b01;
            state    <= ST_RESP;
          end else begin
            cnt_r <= SETTLE_LAST;
            state <= ST_SETTLE;
          end
        end
        ST_LDP: begin
          cnt_r <= SETTLE_LAST;
          state <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (cnt_r == '0) state <= ST_CHECK;
          else             cnt_r <= cnt_r - 1'b1;
        end
        ST_CHECK: begin
          if (op_r == OP_LOAD) begin
            state <= ST_RESP;
          end else if (oor) begin
            status_r <= 2'b01;
            state    <= ST_RESP;
          end else begin
            rem_r <= rem_r - 1'b1;
            state <= (rem_r == TAP_W'(1)) ? ST_RESP : ST_MOVE;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Shadow taps: reload on LOAD pulse, step once per in-range CHECK after a move
  always_ff @(posedge FAB_CLK or posedge ARST) begin
    if (ARST) begin
      for (int i = 0; i < NUM_LANES; i++) taps[i] <= TAP_INIT;
    end else if (state == ST_LDP) begin
      taps[lane_r] <= TAP_INIT;
    end else if (state == ST_CHECK && !op_r[1] && !oor) begin
      taps[lane_r] <= is_inc ? taps[lane_r] + 1'b1 : taps[lane_r] - 1'b1;
    end
  end

  // Handshake, completion and per-lane IOD pulse outputs decoded from state
  always_comb begin
    REQ_READY   = (state == ST_IDLE) && ready_en;
    BUSY        = (state != ST_IDLE);
    DONE        = (state == ST_RESP);
    DONE_STATUS = DONE ? status_r : 2'b00;
    DONE_TAP    = DONE ? cur_tap : '0;
    DELAY_LINE_MOVE      = (state == ST_MOVE && !at_limit) ? lane_hot : '0;
    DELAY_LINE_LOAD      = (state == ST_LDP) ? lane_hot : '0;
    DELAY_LINE_DIRECTION = (is_inc && (state == ST_SETUP || state == ST_MOVE ||
                            state == ST_SETTLE || state == ST_CHECK)) ? lane_hot : '0;
  end

  generate
    for (genvar g = 0; g < NUM_LANES; g++) begin : g_pack
      assign TAP_VALUE[g*TAP_W +: TAP_W] = taps[g];
    end
  endgenerate

endmodule
`default_nettype wire
